// File: rtl/icache.sv
// icache: direct-mapped, read-only, one-word-per-frame instruction cache
// with a single-word miss fill from the memory controller and hit/miss counters.
module icache #(
   parameter int NSETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   input  logic        flush,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);
   localparam int IW = $clog2(NSETS);
   localparam int TW = 30 - IW;
   typedef enum logic {IDLE, FETCH} state_t;
   state_t state, next_state;
   logic [NSETS-1:0] valid;
   logic [TW-1:0] tags [NSETS];
   logic [31:0] data [NSETS];
   logic [31:0] miss_addr;
   logic [IW-1:0] idx, fidx;
   logic [TW-1:0] tag;
   logic hit, miss, fill;
   logic unused_offset;
   assign idx = imemaddr[IW+1:2];
   assign tag = imemaddr[31:IW+2];
   assign fidx = miss_addr[IW+1:2];
   assign unused_offset = ^imemaddr[1:0];
   // flush masks hits and misses alike and beats a completing fill
   always_comb begin
      hit = state == IDLE && imemREN && !flush && valid[idx] && tags[idx] == tag;
      miss = state == IDLE && imemREN && !flush && !hit;
      fill = state == FETCH && !iwait && !flush;
      next_state = flush ? IDLE : (state == IDLE ? (miss ? FETCH : IDLE) : (iwait ? FETCH : IDLE));
      ihit = hit;
      imemload = hit ? data[idx] : '0;
      iREN = state == FETCH;
      iaddr = iREN ? miss_addr : '0;
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         valid <= '0;
         miss_addr <= '0;
         hit_count <= '0;
         miss_count <= '0;
      end else begin
         state <= next_state;
         if (flush) valid <= '0;
         else if (fill) valid[fidx] <= 1'b1;
         if (miss) begin
            miss_addr <= {imemaddr[31:2], 2'b00};
            miss_count <= miss_count + 32'd1;
         end
         if (hit) hit_count <= hit_count + 32'd1;
      end
   end
   always_ff @(posedge CLK) begin
      if (fill && nRST) begin
         tags[fidx] <= miss_addr[31:IW+2];
         data[fidx] <= iload;
      end
   end
endmodule
